// File: rtl/sm4_encryptor_pkg.sv
// Shared types and helpers for the SM4 stream adapter: block geometry,
// beat-count derivation and the packer/serialiser state encodings.
package sm4_encryptor_pkg;

    localparam int group_size_lp  = 128;
    localparam int iv_idx_base_lp = 4;

    function automatic int beats_f(input int data_width);
        return group_size_lp / data_width;
    endfunction

    // A single-beat block would still need a 1-bit counter to stay legal.
    function automatic int cnt_width_f(input int beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

    typedef enum logic {
        eFill,
        eIssue
    } in_state_e;

    typedef enum logic {
        eEmpty,
        eDrain
    } out_state_e;

endpackage

// File: rtl/sm4_block_serializer.sv
// Holds one captured 128-bit result and emits it MSB-first as data_width_p beats
// under a valid/yumi handshake.
module sm4_block_serializer
    import sm4_encryptor_pkg::*;
#(
    parameter int data_width_p = 32
) (
    input  logic                    clk_i,
    input  logic                    reset_n_i,
    input  logic                    load_i,
    input  logic [127:0]            block_i,
    input  logic                    out_yumi_i,
    output logic                    empty_o,
    output logic [data_width_p-1:0] out_o,
    output logic                    out_v_o
);

    localparam int beats_lp = beats_f(data_width_p);
    localparam int cnt_w_lp = cnt_width_f(beats_lp);
    localparam logic [cnt_w_lp-1:0] last_cnt_lp = cnt_w_lp'(beats_lp - 1);

    out_state_e            state_q, state_d;
    logic [127:0]          buf_q, buf_d;
    logic [cnt_w_lp-1:0]   cnt_q, cnt_d;

    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        cnt_d   = cnt_q;
        case (state_q)
            eEmpty: begin
                if (load_i) begin
                    buf_d   = block_i;
                    cnt_d   = '0;
                    state_d = eDrain;
                end
            end
            eDrain: begin
                if (out_yumi_i) begin
                    buf_d = buf_q << data_width_p;
                    if (cnt_q == last_cnt_lp) begin
                        cnt_d   = '0;
                        state_d = eEmpty;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = eEmpty;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= eEmpty;
            buf_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            cnt_q   <= cnt_d;
        end
    end

    // Empty is registered, so a buffer freed by the final yumi reloads next cycle.
    assign empty_o = (state_q == eEmpty);
    assign out_v_o = (state_q == eDrain);
    assign out_o   = buf_q[127 -: data_width_p];

endmodule

// File: rtl/sm4_stream_adapter.sv
// Word-serial front/back end for the SM4 block core: packs beats into blocks,
// issues them with a latched key, and serialises results. Define
// SM4_ADAPTER_CBC_EN to add CBC chaining with an IV register.
module sm4_stream_adapter
    import sm4_encryptor_pkg::*;
#(
    parameter int data_width_p = 32
) (
    input  logic                    clk_i,
    input  logic                    reset_n_i,
    input  logic [data_width_p-1:0] data_i,
    input  logic                    decode_i,
    input  logic                    data_v_i,
    output logic                    data_ready_o,
    input  logic [31:0]             key_word_i,
    input  logic [2:0]              key_idx_i,
    input  logic                    key_we_i,
    output logic                    key_ready_o,
    output logic [127:0]            core_content_o,
    output logic [127:0]            core_key_o,
    output logic                    core_decode_o,
    output logic                    core_v_o,
    input  logic                    core_ready_i,
    input  logic [127:0]            core_crypt_i,
    input  logic                    core_v_i,
    output logic                    core_yumi_o,
    output logic [data_width_p-1:0] out_o,
    output logic                    out_v_o,
    input  logic                    out_yumi_i
);

    localparam int beats_lp = beats_f(data_width_p);
    localparam int cnt_w_lp = cnt_width_f(beats_lp);
    localparam logic [cnt_w_lp-1:0] last_beat_lp = cnt_w_lp'(beats_lp - 1);

    in_state_e           in_q, in_d;
    logic [cnt_w_lp-1:0] beat_q, beat_d;
    logic [127:0]        blk_q, blk_d;
    logic [127:0]        key_q, key_d;
    logic                dec_q, dec_d;
    logic                inflight_q, inflight_d;

    logic                accept, issue, capture, ser_empty, key_wr;
    logic [127:0]        ser_block;

    assign data_ready_o = (in_q == eFill);
    assign core_v_o     = (in_q == eIssue);
    assign accept       = data_v_i & data_ready_o;
    assign issue        = core_v_o & core_ready_i;
    assign capture      = core_v_i & ser_empty;
    assign core_yumi_o  = capture;
    assign key_ready_o  = (in_q == eFill) & ~inflight_q & ser_empty;
    assign key_wr       = key_we_i & key_ready_o;
    assign core_key_o   = key_q;
    assign core_decode_o = dec_q;

    // Packer: shift beats in MSB-first, direction taken from the first beat.
    always_comb begin
        in_d   = in_q;
        beat_d = beat_q;
        blk_d  = blk_q;
        dec_d  = dec_q;
        case (in_q)
            eFill: begin
                if (accept) begin
                    blk_d = {blk_q[127-data_width_p:0], data_i};
                    if (beat_q == '0) dec_d = decode_i;
                    if (beat_q == last_beat_lp) begin
                        beat_d = '0;
                        in_d   = eIssue;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            eIssue: begin
                if (issue) in_d = eFill;
            end
            default: in_d = eFill;
        endcase
    end

    always_comb begin
        inflight_d = inflight_q;
        if (issue)   inflight_d = 1'b1;
        if (capture) inflight_d = 1'b0;
    end

    always_comb begin
        key_d = key_q;
        if (key_wr && (key_idx_i < 3'(iv_idx_base_lp)))
            key_d[32*(3 - int'(key_idx_i[1:0])) +: 32] = key_word_i;
    end

`ifdef SM4_ADAPTER_CBC_EN
    logic [127:0] iv_q, iv_d;
    logic [127:0] chain_q, chain_d;
    logic [127:0] mask_q, mask_d;
    logic         fl_dec_q, fl_dec_d;

    // Decrypt must xor its result with the chain value from before its own issue,
    // so that value is parked in mask_q while chain_q moves on to the ciphertext.
    always_comb begin
        iv_d     = iv_q;
        chain_d  = chain_q;
        mask_d   = mask_q;
        fl_dec_d = fl_dec_q;
        if (key_wr && (key_idx_i >= 3'(iv_idx_base_lp))) begin
            iv_d[32*(7 - int'(key_idx_i)) +: 32] = key_word_i;
            chain_d = iv_d;
        end
        if (capture && !fl_dec_q) chain_d = core_crypt_i;
        if (issue) begin
            fl_dec_d = dec_q;
            mask_d   = dec_q ? chain_q : '0;
            if (dec_q) chain_d = blk_q;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            iv_q     <= '0;
            chain_q  <= '0;
            mask_q   <= '0;
            fl_dec_q <= 1'b0;
        end else begin
            iv_q     <= iv_d;
            chain_q  <= chain_d;
            mask_q   <= mask_d;
            fl_dec_q <= fl_dec_d;
        end
    end

    assign core_content_o = dec_q ? blk_q : (blk_q ^ chain_q);
    assign ser_block      = core_crypt_i ^ mask_q;
`else
    assign core_content_o = blk_q;
    assign ser_block      = core_crypt_i;
`endif

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            in_q       <= eFill;
            beat_q     <= '0;
            blk_q      <= '0;
            key_q      <= '0;
            dec_q      <= 1'b0;
            inflight_q <= 1'b0;
        end else begin
            in_q       <= in_d;
            beat_q     <= beat_d;
            blk_q      <= blk_d;
            key_q      <= key_d;
            dec_q      <= dec_d;
            inflight_q <= inflight_d;
        end
    end

    sm4_block_serializer #(
        .data_width_p(data_width_p)
    ) u_ser (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .load_i    (capture),
        .block_i   (ser_block),
        .out_yumi_i(out_yumi_i),
        .empty_o   (ser_empty),
        .out_o     (out_o),
        .out_v_o   (out_v_o)
    );

endmodule

// File: tb/tb_sm4_stream_adapter.sv
// Scoreboard bench for sm4_stream_adapter with a behavioural core model that
// returns the published SM4 vector pair and a reversible stand-in otherwise.
module tb_sm4_stream_adapter;

    localparam logic [127:0] K  = 128'h0123456789abcdeffedcba9876543210;
    localparam logic [127:0] P  = 128'h0123456789abcdeffedcba9876543210;
    localparam logic [127:0] C  = 128'h681edf34d206965e86b3e94f536e4246;
    localparam logic [127:0] K2 = 128'hdeadbeef00112233445566778899aabb;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [31:0]  data_i = '0;
    logic         decode_i = 1'b0;
    logic         data_v_i = 1'b0;
    logic         data_ready_o;
    logic [31:0]  key_word_i = '0;
    logic [2:0]   key_idx_i = '0;
    logic         key_we_i = 1'b0;
    logic         key_ready_o;
    logic [127:0] core_content_o, core_key_o;
    logic         core_decode_o, core_v_o, core_ready_i, core_v_i, core_yumi_o;
    logic [127:0] core_crypt_i;
    logic [31:0]  out_o;
    logic         out_v_o;
    logic         out_yumi_i = 1'b0;

    int nvec = 0;
    int nerr = 0;
    logic [31:0]  exp_q[$];
    logic [127:0] key_m = '0;
    logic [127:0] chain_m = '0;

    always #5 clk = ~clk;

    sm4_stream_adapter #(.data_width_p(32)) dut (
        .clk_i(clk), .reset_n_i(rst_n),
        .data_i(data_i), .decode_i(decode_i), .data_v_i(data_v_i), .data_ready_o(data_ready_o),
        .key_word_i(key_word_i), .key_idx_i(key_idx_i), .key_we_i(key_we_i), .key_ready_o(key_ready_o),
        .core_content_o(core_content_o), .core_key_o(core_key_o), .core_decode_o(core_decode_o),
        .core_v_o(core_v_o), .core_ready_i(core_ready_i), .core_crypt_i(core_crypt_i),
        .core_v_i(core_v_i), .core_yumi_o(core_yumi_o),
        .out_o(out_o), .out_v_o(out_v_o), .out_yumi_i(out_yumi_i)
    );

    function automatic logic [127:0] core_fn(input logic [127:0] k, input logic [127:0] x, input logic d);
        if (k == K && !d && x == P) return C;
        if (k == K &&  d && x == C) return P;
        if (d) return {x[36:0], x[127:37]} ^ k;
        return {x[90:0] ^ k[90:0], x[127:91] ^ k[127:91]};
    endfunction

    // Core model: accepts when idle, answers after a few cycles, holds until yumi.
    logic         busy_m, res_v_m, dec_m;
    logic [127:0] in_m, k_m;
    int           dly_m;
    assign core_ready_i = ~busy_m;
    assign core_v_i     = res_v_m;
    assign core_crypt_i = core_fn(k_m, in_m, dec_m);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_m <= 1'b0; res_v_m <= 1'b0; dec_m <= 1'b0;
            in_m <= '0; k_m <= '0; dly_m <= 0;
        end else if (!busy_m) begin
            if (core_v_o) begin
                busy_m <= 1'b1; in_m <= core_content_o; k_m <= core_key_o;
                dec_m <= core_decode_o; dly_m <= 2;
            end
        end else if (res_v_m) begin
            if (core_yumi_o) begin
                res_v_m <= 1'b0; busy_m <= 1'b0;
            end
        end else if (dly_m == 0) begin
            res_v_m <= 1'b1;
        end else begin
            dly_m <= dly_m - 1;
        end
    end

    // Monitor: every consumed output beat is checked against the scoreboard.
    always @(negedge clk) begin
        if (rst_n && out_v_o && out_yumi_i) begin
            nvec++;
            if (exp_q.size() == 0) begin
                nerr++;
                $display("FAIL out_beat: got %h, expected no beat", out_o);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if (out_o !== e) begin
                    nerr++;
                    $display("FAIL out_beat: got %h expected %h", out_o, e);
                end
            end
        end
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_blk(input logic [127:0] b);
        for (int i = 0; i < 4; i++) exp_q.push_back(b[127-32*i -: 32]);
    endtask

    function automatic logic [127:0] model_blk(input logic [127:0] b, input logic d);
        logic [127:0] r;
`ifdef SM4_ADAPTER_CBC_EN
        if (!d) begin
            r = core_fn(key_m, b ^ chain_m, 1'b0);
            chain_m = r;
        end else begin
            r = core_fn(key_m, b, 1'b1) ^ chain_m;
            chain_m = b;
        end
`else
        r = core_fn(key_m, b, d);
`endif
        return r;
    endfunction

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    task automatic write_word(input logic [2:0] idx, input logic [31:0] w);
        key_idx_i = idx; key_word_i = w; key_we_i = 1'b1;
        cyc();
        key_we_i = 1'b0;
    endtask

    task automatic write_key(input logic [127:0] k);
        for (int i = 0; i < 4; i++) write_word(3'(i), k[127-32*i -: 32]);
    endtask

    task automatic reload_iv();
        for (int i = 4; i < 8; i++) write_word(3'(i), 32'h0);
        chain_m = '0;
    endtask

    task automatic send_block(input logic [127:0] b, input logic d, input bit gap);
        for (int i = 0; i < 4; i++) begin
            bit done;
            done = 1'b0;
            data_i = b[127-32*i -: 32]; decode_i = d; data_v_i = 1'b1;
            for (int t = 0; t < 500 && !done; t++) begin
                @(negedge clk);
                if (data_ready_o) begin
                    done = 1'b1;
                    cyc();
                end
            end
            if (!done) begin
                nvec++; nerr++;
                $display("FAIL beat_accept: got no data_ready_o within 500 cycles, expected acceptance");
            end
            if (gap && i == 1) begin
                data_v_i = 1'b0;
                cyc(); cyc();
            end
        end
        data_v_i = 1'b0;
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 2000) begin
            cyc();
            t++;
        end
        nvec++;
        if (exp_q.size() != 0) begin
            nerr++;
            $display("FAIL drain: got %0d beats outstanding, expected 0", exp_q.size());
            exp_q.delete();
        end
        repeat (2) cyc();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_data_ready"}, 128'(data_ready_o), 128'(1));
        check({tag, "_key_ready"},  128'(key_ready_o),  128'(1));
        check({tag, "_core_v"},     128'(core_v_o),     128'(0));
        check({tag, "_core_yumi"},  128'(core_yumi_o),  128'(0));
        check({tag, "_out_v"},      128'(out_v_o),      128'(0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) cyc();
        check_reset_outputs("reset");
        rst_n = 1'b1;
        cyc();

        // ECB encrypt of the published vector, with a gap between beats
        out_yumi_i = 1'b1;
        write_key(K); key_m = K;
        reload_iv();
        push_blk(C);
        send_block(P, 1'b0, 1'b1);
        wait_drain();

        // ECB decrypt back to plaintext
        reload_iv();
        push_blk(P);
        send_block(C, 1'b1, 1'b0);
        wait_drain();

        // Backpressure over three blocks, plus a key write that must be dropped
        reload_iv();
        out_yumi_i = 1'b0;
        push_blk(model_blk(P, 1'b0));
        send_block(P, 1'b0, 1'b0);
        push_blk(model_blk(C, 1'b1));
        send_block(C, 1'b1, 1'b0);
        push_blk(model_blk(P, 1'b0));
        send_block(P, 1'b0, 1'b0);
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            check("bp_core_yumi", 128'(core_yumi_o), 128'(0));
        end
        cyc();
        check("bp_out_v", 128'(out_v_o), 128'(1));
        check("bp_key_ready", 128'(key_ready_o), 128'(0));
        write_key(K2);
        out_yumi_i = 1'b1;
        wait_drain();
        check("bp_key_ready_after", 128'(key_ready_o), 128'(1));

`ifdef SM4_ADAPTER_CBC_EN
        // CBC with IV=0: identical plaintexts give distinct ciphertexts
        reload_iv();
        push_blk(C);
        send_block(P, 1'b0, 1'b0);
        push_blk(core_fn(K, P ^ C, 1'b0));
        send_block(P, 1'b0, 1'b0);
        wait_drain();
        reload_iv();
        push_blk(P);
        send_block(C, 1'b1, 1'b0);
        push_blk(P);
        send_block(core_fn(K, P ^ C, 1'b0), 1'b1, 1'b0);
        wait_drain();
`endif

        // Reset while a block waits in eIssue behind a held core result
        out_yumi_i = 1'b0;
        reload_iv();
        push_blk(model_blk(P, 1'b0));
        send_block(P, 1'b0, 1'b0);
        push_blk(model_blk(C, 1'b1));
        send_block(C, 1'b1, 1'b0);
        send_block(P, 1'b0, 1'b0);
        repeat (3) cyc();
        check("pre_rst_core_v", 128'(core_v_o), 128'(1));
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check_reset_outputs("midrst");
        repeat (2) cyc();
        rst_n = 1'b1;
        key_m = '0; chain_m = '0;
        cyc();
        out_yumi_i = 1'b1;
        push_blk(model_blk(P, 1'b0));
        send_block(P, 1'b0, 1'b0);
        wait_drain();
        check("final_out_v", 128'(out_v_o), 128'(0));

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
